// File: rtl/writeback_arbiter_if.sv
// Signal bundle between ID/pipeline/long-latency unit and the register-file writeback arbiter.
// The slave modport is the arbiter's view; master is the environment driving it.
interface writeback_arbiter_if;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        lu_valid;
  logic [4:0]  lu_reg;
  logic [31:0] lu_data;
  logic        lu_ready;
  logic        issue_valid;
  logic [4:0]  issue_reg;
  logic [4:0]  chk_reg1;
  logic [4:0]  chk_reg2;
  logic        pending1;
  logic        pending2;
  logic        reg_write;
  logic [4:0]  write_register;
  logic [31:0] write_data;
  logic        drained;

  modport slave (
    input  wb_valid, wb_reg, wb_data,
    input  lu_valid, lu_reg, lu_data,
    output lu_ready,
    input  issue_valid, issue_reg,
    input  chk_reg1, chk_reg2,
    output pending1, pending2,
    output reg_write, write_register, write_data,
    output drained
  );

  modport master (
    output wb_valid, wb_reg, wb_data,
    output lu_valid, lu_reg, lu_data,
    input  lu_ready,
    output issue_valid, issue_reg,
    output chk_reg1, chk_reg2,
    input  pending1, pending2,
    input  reg_write, write_register, write_data,
    input  drained
  );
endinterface

// File: rtl/writeback_arbiter.sv
// Register-file write-port arbiter: unstallable pipeline writeback beats a FIFO of
// long-latency results; a 32-bit scoreboard tracks registers awaiting long-latency results.
module writeback_arbiter #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input logic               clk,
  input logic               reset,
  writeback_arbiter_if.slave bus
);

  localparam int unsigned CW = AW + 1;

  logic [4:0]    fifo_reg_q  [DEPTH];
  logic [31:0]   fifo_data_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   sb_q, sb_d;
  logic          reg_write_q, reg_write_d;
  logic [4:0]    write_register_q, write_register_d;
  logic [31:0]   write_data_q, write_data_d;

  logic        full;
  logic        push;
  logic        pop;
  logic [4:0]  head_reg;
  logic [31:0] head_data;

  // Ready comes from registered count only, so a same-cycle pop never opens a slot.
  assign full      = (count_q == CW'(DEPTH));
  assign push      = bus.lu_valid & ~full;
  assign pop       = ~bus.wb_valid & (count_q != '0);
  assign head_reg  = fifo_reg_q[rd_ptr_q];
  assign head_data = fifo_data_q[rd_ptr_q];

  always_comb begin
    reg_write_d      = 1'b0;
    write_register_d = write_register_q;
    write_data_d     = write_data_q;
    wr_ptr_d         = wr_ptr_q;
    rd_ptr_d         = rd_ptr_q;
    count_d          = count_q;
    sb_d             = sb_q;

    if (bus.wb_valid) begin
      reg_write_d      = (bus.wb_reg != 5'd0);
      write_register_d = bus.wb_reg;
      write_data_d     = bus.wb_data;
    end else if (pop) begin
      reg_write_d      = (head_reg != 5'd0);
      write_register_d = head_reg;
      write_data_d     = head_data;
      rd_ptr_d         = rd_ptr_q + AW'(1);
      sb_d[head_reg]   = 1'b0;
    end

    // Applied after the clear so a same-cycle set wins.
    if (bus.issue_valid && (bus.issue_reg != 5'd0)) begin
      sb_d[bus.issue_reg] = 1'b1;
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_write_q      <= 1'b0;
      write_register_q <= 5'd0;
      write_data_q     <= 32'd0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      sb_q             <= 32'd0;
    end else begin
      reg_write_q      <= reg_write_d;
      write_register_q <= write_register_d;
      write_data_q     <= write_data_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      count_q          <= count_d;
      sb_q             <= sb_d;
    end
  end

  // Payload storage needs no reset; validity is carried by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_reg_q[wr_ptr_q]  <= bus.lu_reg;
      fifo_data_q[wr_ptr_q] <= bus.lu_data;
    end
  end

  assign bus.lu_ready       = ~full;
  assign bus.pending1       = sb_q[bus.chk_reg1];
  assign bus.pending2       = sb_q[bus.chk_reg2];
  assign bus.reg_write      = reg_write_q;
  assign bus.write_register = write_register_q;
  assign bus.write_data     = write_data_q;
  assign bus.drained        = (count_q == '0) && (sb_q == 32'd0);

endmodule

// File: tb/tb_writeback_arbiter.sv
// Randomized and directed bench for writeback_arbiter against a queue-based reference model.
module tb_writeback_arbiter;
  localparam int DEPTH = 2;

  logic clk;
  logic reset;
  writeback_arbiter_if bus ();

  writeback_arbiter #(.DEPTH(DEPTH)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model: FIFO as queues, scoreboard as a bit vector, last write-port value.
  logic [4:0]  mq_reg[$];
  logic [31:0] mq_data[$];
  logic [31:0] msb;
  logic        m_we;
  logic [4:0]  m_wr;
  logic [31:0] m_wd;

  task automatic model_reset();
    mq_reg.delete();
    mq_data.delete();
    msb  = '0;
    m_we = 1'b0;
    m_wr = '0;
    m_wd = '0;
  endtask

  function automatic logic [41:0] exp_vec();
    logic rdy;
    logic drn;
    rdy = (mq_reg.size() < DEPTH);
    drn = (mq_reg.size() == 0) && (msb == 32'd0);
    return {rdy, msb[bus.chk_reg1], msb[bus.chk_reg2], m_we, m_wr, m_wd, drn};
  endfunction

  function automatic logic [41:0] dut_vec();
    return {bus.lu_ready, bus.pending1, bus.pending2, bus.reg_write, bus.write_register,
            bus.write_data, bus.drained};
  endfunction

  task automatic idle_inputs();
    bus.wb_valid    = 1'b0;
    bus.wb_reg      = '0;
    bus.wb_data     = '0;
    bus.lu_valid    = 1'b0;
    bus.lu_reg      = '0;
    bus.lu_data     = '0;
    bus.issue_valid = 1'b0;
    bus.issue_reg   = '0;
    bus.chk_reg1    = '0;
    bus.chk_reg2    = '0;
  endtask

  // Advance one clock, stepping the model with the inputs present before the edge.
  task automatic tick();
    logic        rdy;
    logic [4:0]  r;
    logic [31:0] d;
    if (reset) begin
      model_reset();
    end else begin
      rdy = (mq_reg.size() < DEPTH);
      if (bus.wb_valid) begin
        m_we = (bus.wb_reg != 5'd0);
        m_wr = bus.wb_reg;
        m_wd = bus.wb_data;
      end else if (mq_reg.size() > 0) begin
        r = mq_reg.pop_front();
        d = mq_data.pop_front();
        m_we   = (r != 5'd0);
        m_wr   = r;
        m_wd   = d;
        msb[r] = 1'b0;
      end else begin
        m_we = 1'b0;
      end
      if (bus.lu_valid && rdy) begin
        mq_reg.push_back(bus.lu_reg);
        mq_data.push_back(bus.lu_data);
      end
      if (bus.issue_valid && bus.issue_reg != 5'd0) msb[bus.issue_reg] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    model_reset();
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    n_checks++;
    if (dut_vec() !== exp_vec()) begin
      n_fails++;
      $display("FAIL reset_idle got %h exp %h", dut_vec(), exp_vec());
    end
    n_checks++;
    if ({bus.reg_write, bus.lu_ready, bus.drained, bus.pending1, bus.pending2} !== 5'b01100) begin
      n_fails++;
      $display("FAIL reset_consts got %b exp 01100",
               {bus.reg_write, bus.lu_ready, bus.drained, bus.pending1, bus.pending2});
    end
  endtask

  task automatic test_wb_write();
    bus.wb_valid = 1'b1;
    bus.wb_reg   = 5'd5;
    bus.wb_data  = 32'hDEADBEEF;
    tick();
    n_checks++;
    if ({bus.reg_write, bus.write_register, bus.write_data} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
      n_fails++;
      $display("FAIL wb_write got %b %0d %h exp 1 5 deadbeef",
               bus.reg_write, bus.write_register, bus.write_data);
    end
    bus.wb_reg  = 5'd0;
    bus.wb_data = 32'h0BADF00D;
    tick();
    n_checks++;
    if (bus.reg_write !== 1'b0 || dut_vec() !== exp_vec()) begin
      n_fails++;
      $display("FAIL wb_reg0 got %h exp %h", dut_vec(), exp_vec());
    end
    idle_inputs();
    tick();
    n_checks++;
    if (bus.reg_write !== 1'b0 || bus.write_data !== 32'h0BADF00D) begin
      n_fails++;
      $display("FAIL wb_hold got we=%b data=%h exp we=0 data=0badf00d",
               bus.reg_write, bus.write_data);
    end
  endtask

  task automatic test_lu_path();
    idle_inputs();
    bus.chk_reg1    = 5'd8;
    bus.issue_valid = 1'b1;
    bus.issue_reg   = 5'd8;
    tick();
    bus.issue_valid = 1'b0;
    n_checks++;
    if (bus.pending1 !== 1'b1 || bus.drained !== 1'b0) begin
      n_fails++;
      $display("FAIL lu_issue got pend=%b drn=%b exp pend=1 drn=0", bus.pending1, bus.drained);
    end
    bus.lu_valid = 1'b1;
    bus.lu_reg   = 5'd8;
    bus.lu_data  = 32'h12345678;
    tick();
    bus.lu_valid = 1'b0;
    n_checks++;
    if (bus.pending1 !== 1'b1 || bus.reg_write !== 1'b0) begin
      n_fails++;
      $display("FAIL lu_pushed got pend=%b we=%b exp pend=1 we=0", bus.pending1, bus.reg_write);
    end
    tick();
    n_checks++;
    if ({bus.reg_write, bus.write_register, bus.write_data, bus.pending1, bus.drained} !==
        {1'b1, 5'd8, 32'h12345678, 1'b0, 1'b1}) begin
      n_fails++;
      $display("FAIL lu_write got we=%b reg=%0d data=%h pend=%b drn=%b exp 1 8 12345678 0 1",
               bus.reg_write, bus.write_register, bus.write_data, bus.pending1, bus.drained);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  regs [3];
    logic [31:0] datas[3];
    for (int i = 0; i < 3; i++) begin
      regs[i]  = 5'(10 + i);
      datas[i] = $urandom;
    end
    idle_inputs();
    bus.wb_valid = 1'b1;
    bus.wb_reg   = 5'd1;
    bus.wb_data  = 32'h1;
    bus.lu_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.lu_reg  = regs[i];
      bus.lu_data = datas[i];
      tick();
    end
    bus.lu_reg  = regs[2];
    bus.lu_data = datas[2];
    n_checks++;
    if (bus.lu_ready !== 1'b0) begin
      n_fails++;
      $display("FAIL b2b_full got lu_ready=%b exp 0", bus.lu_ready);
    end
    tick();
    tick();
    n_checks++;
    if (dut_vec() !== exp_vec() || bus.lu_ready !== 1'b0) begin
      n_fails++;
      $display("FAIL b2b_starved got %h exp %h", dut_vec(), exp_vec());
    end
    bus.wb_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 1) bus.lu_valid = 1'b0;  // third offer accepted at this edge
      n_checks++;
      if ({bus.reg_write, bus.write_register, bus.write_data} !== {1'b1, regs[i], datas[i]}) begin
        n_fails++;
        $display("FAIL b2b_order%0d got %b %0d %h exp 1 %0d %h", i, bus.reg_write,
                 bus.write_register, bus.write_data, regs[i], datas[i]);
      end
    end
    tick();
    n_checks++;
    if (bus.drained !== 1'b1 || bus.reg_write !== 1'b0) begin
      n_fails++;
      $display("FAIL b2b_drained got drn=%b we=%b exp 1 0", bus.drained, bus.reg_write);
    end
  endtask

  task automatic test_set_clear_same();
    idle_inputs();
    bus.chk_reg2    = 5'd9;
    bus.issue_valid = 1'b1;
    bus.issue_reg   = 5'd9;
    tick();
    bus.issue_valid = 1'b0;
    bus.lu_valid    = 1'b1;
    bus.lu_reg      = 5'd9;
    bus.lu_data     = 32'hCAFE0009;
    tick();
    bus.lu_valid    = 1'b0;
    bus.issue_valid = 1'b1;  // re-issue coincides with the pop of reg 9
    tick();
    bus.issue_valid = 1'b0;
    n_checks++;
    if (bus.pending2 !== 1'b1 || bus.reg_write !== 1'b1 || bus.write_register !== 5'd9) begin
      n_fails++;
      $display("FAIL set_wins got pend=%b we=%b reg=%0d exp 1 1 9",
               bus.pending2, bus.reg_write, bus.write_register);
    end
    bus.lu_valid = 1'b1;
    tick();
    bus.lu_valid = 1'b0;
    tick();
    n_checks++;
    if (bus.pending2 !== 1'b0 || dut_vec() !== exp_vec()) begin
      n_fails++;
      $display("FAIL set_retire got %h exp %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_mid_reset();
    idle_inputs();
    bus.wb_valid    = 1'b1;
    bus.wb_reg      = 5'd2;
    bus.lu_valid    = 1'b1;
    bus.issue_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.issue_reg = 5'(20 + i);
      bus.lu_reg    = 5'(20 + i);
      bus.lu_data   = $urandom;
      tick();
    end
    idle_inputs();
    bus.wb_valid = 1'b1;  // keep the FIFO from draining
    bus.chk_reg1 = 5'd20;
    bus.chk_reg2 = 5'd22;
    #1;
    n_checks++;
    if (bus.lu_ready !== 1'b0 || bus.pending1 !== 1'b1 || bus.pending2 !== 1'b1) begin
      n_fails++;
      $display("FAIL midrst_pre got rdy=%b p1=%b p2=%b exp 0 1 1",
               bus.lu_ready, bus.pending1, bus.pending2);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if ({bus.lu_ready, bus.pending1, bus.pending2, bus.reg_write, bus.write_register,
         bus.write_data, bus.drained} !== {1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1}) begin
      n_fails++;
      $display("FAIL midrst_async got %h exp 2_0000_0000_01", dut_vec());
    end
    model_reset();
    idle_inputs();
    tick();
    reset = 1'b0;
    tick();
    tick();
    n_checks++;
    if (bus.reg_write !== 1'b0 || dut_vec() !== exp_vec()) begin
      n_fails++;
      $display("FAIL midrst_after got %h exp %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    int errs;
    logic acc;
    errs = 0;
    idle_inputs();
    for (int c = 0; c < 400; c++) begin
      bus.wb_valid    = ($urandom_range(0, 99) < 45);
      bus.wb_reg      = 5'($urandom);
      bus.wb_data     = $urandom;
      bus.issue_valid = ($urandom_range(0, 99) < 30);
      bus.issue_reg   = 5'($urandom);
      bus.chk_reg1    = 5'($urandom);
      bus.chk_reg2    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      if (!bus.lu_valid) begin
        bus.lu_valid = ($urandom_range(0, 99) < 50);
        bus.lu_reg   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        bus.lu_data  = $urandom;
      end
      #1;
      acc = bus.lu_valid && bus.lu_ready;
      tick();
      if (acc) bus.lu_valid = 1'b0;
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fails++;
        errs++;
        if (errs <= 10) $display("FAIL random c=%0d got %h exp %h", c, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    model_reset();
    test_reset();
    test_wb_write();
    test_lu_path();
    test_back_to_back();
    test_set_clear_same();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
